// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache:
// address field layout, line geometry and the miss-handling FSM states.
package dcache_pkg;

   localparam int NUM_LINES = 32;
   localparam int IDX_W     = 5;
   localparam int LINE_W    = 256;
   localparam int WORD_W    = 32;
   localparam int TAG_W     = 32 - IDX_W - 5;

   localparam int OFF_LO    = 2;
   localparam int OFF_HI    = 4;
   localparam int IDX_LO    = 5;
   localparam int IDX_HI    = IDX_LO + IDX_W - 1;
   localparam int TAG_LO    = IDX_HI + 1;
   localparam int TAG_HI    = 31;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      REFILL    = 2'd3
   } state_t;

   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
      return {tag, idx, 5'b00000};
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, single synchronous write
// port; only valid/dirty are cleared by reset.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [LINE_W-1:0] rd_line,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic              wr_dirty,
   input  logic [LINE_W-1:0] wr_line
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [LINE_W-1:0]    data_mem [NUM_LINES];

   assign rd_tag   = tag_mem[rd_idx];
   assign rd_line  = data_mem[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= wr_dirty;
      end
   end

   // Tag and data contents survive reset; valid bits alone gate their use.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// L1 data cache controller: hit detection, word select/merge, miss FSM with
// write-back of dirty victims and line allocation over a request/ack bus.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_MemRead_i,
   input  logic              cpu_MemWrite_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   state_t              state, next_state;
   logic                req, hit, serve;
   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    addr_tag;
   logic [2:0]          off;
   logic [TAG_W-1:0]    rd_tag;
   logic                rd_valid, rd_dirty;
   logic [LINE_W-1:0]   rd_line;
   logic                wr_en, wr_dirty;
   logic [LINE_W-1:0]   wr_line;
   logic [LINE_W-1:0]   fill_line;
   logic                unused_byte_bits;

   function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                  input logic [2:0] w);
      return line[{w, 5'b00000} +: WORD_W];
   endfunction

   function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                  input logic [2:0] w,
                                                  input logic [WORD_W-1:0] data);
      logic [LINE_W-1:0] merged;
      merged = line;
      merged[{w, 5'b00000} +: WORD_W] = data;
      return merged;
   endfunction

   assign idx              = cpu_addr_i[IDX_HI:IDX_LO];
   assign addr_tag         = cpu_addr_i[TAG_HI:TAG_LO];
   assign off              = cpu_addr_i[OFF_HI:OFF_LO];
   assign unused_byte_bits = ^cpu_addr_i[1:0];

   assign req   = cpu_MemRead_i | cpu_MemWrite_i;
   assign hit   = rd_valid & (rd_tag == addr_tag);
   assign serve = rst_i & req & (state == IDLE) & hit;

   // Stall is combinational so the pipeline freezes in the very cycle a miss appears.
   assign cpu_stall_o = rst_i & req & ~((state == IDLE) & hit);
   assign cpu_data_o  = serve ? get_word(rd_line, off) : '0;

   dcache_sram u_sram (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_idx   (idx),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_line  (rd_line),
      .wr_en    (wr_en),
      .wr_idx   (idx),
      .wr_tag   (addr_tag),
      .wr_dirty (wr_dirty),
      .wr_line  (wr_line)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      wr_en      = 1'b0;
      wr_dirty   = 1'b0;
      wr_line    = rd_line;
      case (state)
         IDLE: begin
            if (req && rst_i) begin
               if (hit) begin
                  if (cpu_MemWrite_i) begin
                     wr_en    = 1'b1;
                     wr_dirty = 1'b1;
                     wr_line  = put_word(rd_line, off, cpu_data_i);
                  end
               end else if (rd_valid && rd_dirty) begin
                  next_state = WRITEBACK;
               end else begin
                  next_state = ALLOCATE;
               end
            end
         end
         WRITEBACK: if (mem_ack_i) next_state = ALLOCATE;
         ALLOCATE:  if (mem_ack_i) next_state = REFILL;
         REFILL: begin
            wr_en      = 1'b1;
            wr_line    = fill_line;
            next_state = IDLE;
         end
         default:   next_state = IDLE;
      endcase
   end

   // Bus outputs are registered from the next state, so they are valid for
   // the whole time the FSM sits in WRITEBACK or ALLOCATE.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
      end else begin
         case (next_state)
            WRITEBACK: begin
               mem_enable_o <= 1'b1;
               mem_write_o  <= 1'b1;
               mem_addr_o   <= line_addr(rd_tag, idx);
               mem_data_o   <= rd_line;
            end
            ALLOCATE: begin
               mem_enable_o <= 1'b1;
               mem_write_o  <= 1'b0;
               mem_addr_o   <= line_addr(addr_tag, idx);
            end
            default: begin
               mem_enable_o <= 1'b0;
               mem_write_o  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (state == ALLOCATE && mem_ack_i) fill_line <= mem_data_i;
   end

endmodule
